// File: rtl/solver_sequencer.sv
// Iteration sequencer for a limb-serial solver: sweeps limbs NUM_PHASES times per iteration,
// checks for divergence or the iteration limit, then holds the result. Optional abort: SOLVER_SEQUENCER_ABORT_EN.
module solver_sequencer #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int ITER_BITS       = 16,
    parameter int NUM_PHASES      = 2,
    parameter int PHASE_BITS      = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_num_limbs_en,
    input  logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
    input  logic                       wr_iter_lim_en,
    input  logic [ITER_BITS-1:0]       iter_lim_data,
    input  logic                       start,
    input  logic                       diverged,
`ifdef SOLVER_SEQUENCER_ABORT_EN
    input  logic                       abort,
`endif
    output logic                       busy,
    output logic                       limb_valid,
    output logic [LIMB_INDEX_BITS-1:0] limb_index,
    output logic [PHASE_BITS-1:0]      phase,
    output logic [ITER_BITS-1:0]       iter_count,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [ITER_BITS-1:0]       result_iters,
    output logic                       result_diverged
);

    // state | meaning
    // IDLE  | config writable, waiting for start
    // STEP  | one limb per cycle, NUM_PHASES sweeps
    // CHECK | end of iteration: count it, test divergence / limit
    // DONE  | result presented until result_ready
    typedef enum logic [1:0] {IDLE, STEP, CHECK, DONE} state_t;

    state_t                     state;
    logic [LIMB_INDEX_BITS-1:0] num_limbs;
    logic [ITER_BITS-1:0]       iter_lim;
    logic                       last_limb;
    logic                       last_phase;
    logic [ITER_BITS-1:0]       iter_next;
    logic                       abort_req;

`ifdef SOLVER_SEQUENCER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign last_limb  = (limb_index == num_limbs - LIMB_INDEX_BITS'(1));
    assign last_phase = (phase == PHASE_BITS'(NUM_PHASES - 1));
    assign iter_next  = iter_count + ITER_BITS'(1);

    assign busy         = (state != IDLE);
    assign limb_valid   = (state == STEP);
    assign result_valid = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            num_limbs       <= LIMB_INDEX_BITS'(1);
            iter_lim        <= ITER_BITS'(1);
            limb_index      <= '0;
            phase           <= '0;
            iter_count      <= '0;
            result_iters    <= '0;
            result_diverged <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_num_limbs_en) num_limbs <= num_limbs_data;
                    if (wr_iter_lim_en)  iter_lim  <= iter_lim_data;
                    if (start && (num_limbs != '0) && (iter_lim != '0)) begin
                        state      <= STEP;
                        limb_index <= '0;
                        phase      <= '0;
                        iter_count <= '0;
                    end
                end
                STEP: begin
                    if (abort_req) begin
                        state           <= DONE;
                        limb_index      <= '0;
                        phase           <= '0;
                        result_iters    <= iter_count;
                        result_diverged <= 1'b0;
                    end else if (last_limb) begin
                        limb_index <= '0;
                        if (last_phase) begin
                            phase <= '0;
                            state <= CHECK;
                        end else begin
                            phase <= phase + PHASE_BITS'(1);
                        end
                    end else begin
                        limb_index <= limb_index + LIMB_INDEX_BITS'(1);
                    end
                end
                CHECK: begin
                    // An abort here reports the iterations finished before this check.
                    if (abort_req) begin
                        state           <= DONE;
                        result_iters    <= iter_count;
                        result_diverged <= 1'b0;
                    end else begin
                        iter_count <= iter_next;
                        if (diverged || (iter_next == iter_lim)) begin
                            state           <= DONE;
                            result_iters    <= iter_next;
                            result_diverged <= diverged;
                        end else begin
                            state <= STEP;
                        end
                    end
                end
                DONE: begin
                    if (result_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_solver_sequencer.sv
// Scoreboard bench for solver_sequencer: expected limb beats and results are queued by the
// stimulus from a sweep-level model; a negedge monitor pops and compares.
module tb_solver_sequencer;

    localparam int LB = 6;
    localparam int IB = 16;
    localparam int NP = 2;
    localparam int PB = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wr_num_limbs_en = 1'b0;
    logic [LB-1:0] num_limbs_data = '0;
    logic          wr_iter_lim_en = 1'b0;
    logic [IB-1:0] iter_lim_data = '0;
    logic          start = 1'b0;
    logic          diverged = 1'b0;
`ifdef SOLVER_SEQUENCER_ABORT_EN
    logic          abort = 1'b0;
`endif
    logic          busy;
    logic          limb_valid;
    logic [LB-1:0] limb_index;
    logic [PB-1:0] phase;
    logic [IB-1:0] iter_count;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [IB-1:0] result_iters;
    logic          result_diverged;

    solver_sequencer #(
        .LIMB_INDEX_BITS(LB), .ITER_BITS(IB), .NUM_PHASES(NP), .PHASE_BITS(PB)
    ) dut (
        .clock(clock), .reset(reset),
        .wr_num_limbs_en(wr_num_limbs_en), .num_limbs_data(num_limbs_data),
        .wr_iter_lim_en(wr_iter_lim_en), .iter_lim_data(iter_lim_data),
        .start(start), .diverged(diverged),
`ifdef SOLVER_SEQUENCER_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .limb_valid(limb_valid), .limb_index(limb_index), .phase(phase),
        .iter_count(iter_count), .result_valid(result_valid), .result_ready(result_ready),
        .result_iters(result_iters), .result_diverged(result_diverged)
    );

    always #5 clock = ~clock;

    typedef struct { int idx; int ph; int it; } limb_t;
    typedef struct { int iters; int div; } res_t;

    limb_t lq[$];
    res_t  rq[$];
    int    checks = 0;
    int    errors = 0;
    int    cfg_n  = 1;
    int    cfg_lim = 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every limb beat and every DONE cycle is matched against the queues.
    always @(negedge clock) begin
        if (limb_valid) begin
            if (lq.size() == 0) begin
                chk("unexpected_limb_beat", 1, 0);
            end else begin
                limb_t e;
                e = lq.pop_front();
                chk("limb_index", limb_index, e.idx);
                chk("phase", phase, e.ph);
                chk("iter_count_step", iter_count, e.it);
                chk("busy_step", busy, 1);
            end
        end
        if (result_valid) begin
            if (rq.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                chk("result_iters", result_iters, rq[0].iters);
                chk("result_diverged", result_diverged, rq[0].div);
                chk("iter_count_done", iter_count, rq[0].iters);
                chk("busy_done", busy, 1);
                if (result_ready) void'(rq.pop_front());
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_limb_valid"}, limb_valid, 0);
        chk({tag, "_limb_index"}, limb_index, 0);
        chk({tag, "_phase"}, phase, 0);
        chk({tag, "_iter_count"}, iter_count, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_result_iters"}, result_iters, 0);
        chk({tag, "_result_diverged"}, result_diverged, 0);
    endtask

    task automatic write_cfg(input int n, input int lim, input bit wn, input bit wl);
        wr_num_limbs_en = wn;
        wr_iter_lim_en  = wl;
        num_limbs_data  = LB'(n);
        iter_lim_data   = IB'(lim);
        tick();
        wr_num_limbs_en = 1'b0;
        wr_iter_lim_en  = 1'b0;
        if (wn) cfg_n = n;
        if (wl) cfg_lim = lim;
    endtask

    task automatic push_iter(input int k, input int beats);
        for (int b = 0; b < beats; b++) lq.push_back('{b % cfg_n, b / cfg_n, k});
    endtask

    // Full solve: model decides divergence per iteration, queues the whole expected run, then drives it.
    task automatic run_solve(input int p_div, input int force_it, input int stall, input bit noise);
        int  s_len;
        int  k_total;
        int  exp_iters;
        bit  dv[$];
        bit  done;
        s_len = NP * cfg_n;
        done = 1'b0;
        k_total = 0;
        exp_iters = 0;
        for (int k = 0; k < cfg_lim && !done; k++) begin
            bit d;
            d = (k == force_it) || ($urandom_range(99) < p_div);
            dv.push_back(d);
            push_iter(k, s_len);
            if (d || (k + 1 == cfg_lim)) begin
                rq.push_back('{k + 1, int'(d)});
                exp_iters = k + 1;
                done = 1'b1;
            end
            k_total = k + 1;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < k_total; k++) begin
            for (int s = 0; s < s_len; s++) begin
                diverged = 1'($urandom_range(1));
                if (noise) begin
                    start           = 1'($urandom_range(1));
                    wr_num_limbs_en = 1'($urandom_range(1));
                    wr_iter_lim_en  = 1'($urandom_range(1));
                    num_limbs_data  = LB'(7);
                    iter_lim_data   = IB'(9);
                end
                tick();
            end
            start = 1'b0;
            wr_num_limbs_en = 1'b0;
            wr_iter_lim_en  = 1'b0;
            diverged = dv[k];
            tick();
            diverged = 1'b0;
        end
        chk("done_reached_on_time", result_valid, 1);
        result_ready = 1'b0;
        repeat (stall) tick();
        result_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        result_ready = 1'b0;
        chk("idle_after_handshake", busy, 0);
        tick();
        chk("start_in_handshake_ignored", busy, 0);
        chk("result_iters_held_idle", result_iters, exp_iters);
        chk("result_div_held_idle", result_diverged, int'(dv[k_total-1]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check_zero("reset");

        // Default config after reset: one limb, one iteration.
        run_solve(0, -1, 0, 1'b0);

        // Both registers loaded in one cycle; 3 iterations of 2x5 limbs.
        write_cfg(5, 3, 1'b1, 1'b1);
        run_solve(0, -1, 0, 1'b1);
        chk("cfg_kept_after_busy_writes", cfg_n, 5);
        // Divergence in the second check, with a 10-cycle stall.
        run_solve(0, 1, 10, 1'b1);

        // Zero limb count or zero limit blocks the start.
        write_cfg(0, 3, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        tick();
        chk("start_blocked_zero_limbs", busy, 0);
        start = 1'b0;
        write_cfg(4, 0, 1'b1, 1'b1);
        start = 1'b1;
        tick();
        tick();
        chk("start_blocked_zero_lim", busy, 0);
        start = 1'b0;

        // Reset mid-way through iteration 2.
        write_cfg(5, 3, 1'b1, 1'b1);
        push_iter(0, NP * 5);
        push_iter(1, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (NP * 5) tick();
        tick();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cfg_n = 1;
        cfg_lim = 1;
        check_zero("midreset");
        run_solve(0, -1, 0, 1'b0);
        write_cfg(0, 0, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        tick();
        chk("start_blocked_after_reset", busy, 0);
        start = 1'b0;

`ifdef SOLVER_SEQUENCER_ABORT_EN
        begin
            int m;
            write_cfg(5, 3, 1'b1, 1'b1);
            m = $urandom_range(NP * 5 - 1);
            push_iter(0, NP * 5);
            push_iter(1, m + 1);
            rq.push_back('{1, 0});
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (NP * 5) tick();
            tick();
            repeat (m) tick();
            abort = 1'b1;
            diverged = 1'b1;
            tick();
            abort = 1'b0;
            diverged = 1'b0;
            chk("abort_done", result_valid, 1);
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
            chk("abort_idle", busy, 0);
        end
`endif

        for (int r = 0; r < 8; r++) begin
            write_cfg(int'($urandom_range(6, 1)), int'($urandom_range(4, 1)), 1'b1, 1'b1);
            run_solve(25, -1, int'($urandom_range(3)), 1'($urandom_range(1)));
        end

        chk("limb_queue_drained", lq.size(), 0);
        chk("result_queue_drained", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
